// File: rtl/evt_counter_mc_if.sv
// Snapshot handshake bundle for evt_counter_mc.
// The consumer drives request/ack and the counter block returns the captured counts.
interface evt_counter_mc_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 16
);
    logic                  snap_req_in;
    logic                  snap_ack_in;
    logic [N_CH*WIDTH-1:0] snap_out;
    logic                  snap_valid_out;
    logic                  snap_ovf_out;

    // Consumer side (UART/display readout)
    modport master (
        output snap_req_in, snap_ack_in,
        input  snap_out, snap_valid_out, snap_ovf_out
    );

    // Counter side
    modport slave (
        input  snap_req_in, snap_ack_in,
        output snap_out, snap_valid_out, snap_ovf_out
    );
endinterface

// File: rtl/evt_counter_mc.sv
// Multi-channel event counter: N_CH independent modulo-MAX_COUNT counters with
// up/down, wrap/saturate, clear, load and a wrap pulse, plus a coherent
// snapshot of all channels behind a valid/ack handshake.

// One counter channel.
module evt_counter_mc_lane #(
    parameter int          WIDTH     = 16,
    parameter int unsigned MAX_COUNT = 40_000
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             evt_in,
    input  logic             dir_in,
    input  logic             sat_mode_in,
    input  logic             clr_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    output logic [WIDTH-1:0] count_out,
    output logic             wrap_out
);
    // Top of the legal range, held at WIDTH bits so MAX_COUNT = 2**WIDTH works.
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_COUNT - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    // Next count: clear > load > event > hold; the count never leaves 0..TOP,
    // so equality against the range ends is enough to detect a boundary.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr_in) begin
            count_d = '0;
        end else if (load_in) begin
            count_d = (load_val_in > TOP) ? TOP : load_val_in;
        end else if (evt_in) begin
            if (dir_in) begin
                if (count_q != TOP) begin
                    count_d = count_q + WIDTH'(1);
                end else if (!sat_mode_in) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else if (!sat_mode_in) begin
                    count_d = TOP;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out = count_q;
    assign wrap_out  = wrap_q;
endmodule

module evt_counter_mc #(
    parameter int          N_CH      = 4,
    parameter int          WIDTH     = 16,
    parameter int unsigned MAX_COUNT = 40_000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [N_CH-1:0]       evt_in,
    input  logic [N_CH-1:0]       dir_in,
    input  logic [N_CH-1:0]       sat_mode_in,
    input  logic [N_CH-1:0]       clr_in,
    input  logic [N_CH-1:0]       load_in,
    input  logic [WIDTH-1:0]      load_val_in,
    output logic [N_CH*WIDTH-1:0] count_out,
    output logic [N_CH-1:0]       wrap_out,
    evt_counter_mc_if.slave       snap
);
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("evt_counter_mc: N_CH must be in 1..16");
    end
    if (MAX_COUNT < 2 || 64'(MAX_COUNT) > (64'd1 << WIDTH)) begin : g_bad_max
        $error("evt_counter_mc: MAX_COUNT must satisfy 2 <= MAX_COUNT <= 2**WIDTH");
    end

    logic [N_CH-1:0][WIDTH-1:0] count;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        evt_counter_mc_lane #(
            .WIDTH     (WIDTH),
            .MAX_COUNT (MAX_COUNT)
        ) u_lane (
            .clk_in      (clk_in),
            .rst_n_in    (rst_n_in),
            .evt_in      (evt_in[i]),
            .dir_in      (dir_in[i]),
            .sat_mode_in (sat_mode_in[i]),
            .clr_in      (clr_in[i]),
            .load_in     (load_in[i]),
            .load_val_in (load_val_in),
            .count_out   (count[i]),
            .wrap_out    (wrap_out[i])
        );
    end

    assign count_out = count;

    logic [N_CH-1:0][WIDTH-1:0] snap_q, snap_d;
    logic                       snap_valid_q, snap_valid_d;
    logic                       snap_ovf_q, snap_ovf_d;

    // Snapshot handshake: an ack frees the holding register first, so a request
    // in the same cycle is captured instead of being counted as an overflow.
    // The capture takes the registered counts, i.e. the pre-update values.
    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        snap_ovf_d   = snap_ovf_q;
        if (snap_valid_q && snap.snap_ack_in) begin
            snap_valid_d = 1'b0;
            snap_ovf_d   = 1'b0;
        end
        if (snap.snap_req_in) begin
            if (!snap_valid_d) begin
                snap_d       = count;
                snap_valid_d = 1'b1;
            end else begin
                snap_ovf_d   = 1'b1;
            end
        end
    end

    // Snapshot holding registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            snap_ovf_q   <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            snap_ovf_q   <= snap_ovf_d;
        end
    end

    assign snap.snap_out       = snap_q;
    assign snap.snap_valid_out = snap_valid_q;
    assign snap.snap_ovf_out   = snap_ovf_q;
endmodule

// File: tb/tb_evt_counter_mc.sv
// Bench for evt_counter_mc: directed vector table, snapshot and reset
// sequences, randomized run against a behavioural model, and parameter corners.
module tb_evt_counter_mc;
    localparam int N = 4;
    localparam int W = 16;
    localparam int M = 40_000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance
    logic [N-1:0]   evt, dir, sat, clr, load;
    logic [W-1:0]   lv;
    logic [N*W-1:0] count;
    logic [N-1:0]   wrap;
    evt_counter_mc_if #(.N_CH(N), .WIDTH(W)) sif ();

    evt_counter_mc #(.N_CH(N), .WIDTH(W), .MAX_COUNT(M)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(evt), .dir_in(dir),
        .sat_mode_in(sat), .clr_in(clr), .load_in(load), .load_val_in(lv),
        .count_out(count), .wrap_out(wrap), .snap(sif)
    );

    // Corner: one channel, WIDTH 4, MAX_COUNT 16 (= 2**WIDTH)
    logic [0:0] b_evt, b_dir, b_sat, b_clr, b_load, b_wrap;
    logic [3:0] b_lv, b_count;
    evt_counter_mc_if #(.N_CH(1), .WIDTH(4)) bif ();

    evt_counter_mc #(.N_CH(1), .WIDTH(4), .MAX_COUNT(16)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(b_evt), .dir_in(b_dir),
        .sat_mode_in(b_sat), .clr_in(b_clr), .load_in(b_load), .load_val_in(b_lv),
        .count_out(b_count), .wrap_out(b_wrap), .snap(bif)
    );

    // Corner: MAX_COUNT 2 with WIDTH 1, two channels
    logic [1:0] c_evt, c_dir, c_sat, c_clr, c_load, c_wrap, c_count;
    logic [0:0] c_lv;
    evt_counter_mc_if #(.N_CH(2), .WIDTH(1)) cif ();

    evt_counter_mc #(.N_CH(2), .WIDTH(1), .MAX_COUNT(2)) dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .evt_in(c_evt), .dir_in(c_dir),
        .sat_mode_in(c_sat), .clr_in(c_clr), .load_in(c_load), .load_val_in(c_lv),
        .count_out(c_count), .wrap_out(c_wrap), .snap(cif)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Behavioural model of the main instance
    int             m_cnt[N];
    bit [N-1:0]     m_wrap;
    logic [N*W-1:0] m_snap;
    bit             m_sv, m_so;

    function automatic logic [N*W-1:0] pack_model();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_cnt[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_wrap = '0; m_snap = '0; m_sv = 0; m_so = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (m_sv && sif.snap_ack_in) begin
            m_sv = 0;
            m_so = 0;
        end
        if (sif.snap_req_in) begin
            if (!m_sv) begin
                m_snap = pack_model();
                m_sv   = 1;
            end else begin
                m_so = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_wrap[i] = 0;
            if (clr[i]) begin
                m_cnt[i] = 0;
            end else if (load[i]) begin
                m_cnt[i] = (int'(lv) > M - 1) ? M - 1 : int'(lv);
            end else if (evt[i]) begin
                if (dir[i]) begin
                    if (!sat[i] || m_cnt[i] < M - 1) begin
                        m_wrap[i] = (m_cnt[i] == M - 1);
                        m_cnt[i]  = (m_cnt[i] + 1) % M;
                    end
                end else begin
                    if (!sat[i] || m_cnt[i] > 0) begin
                        m_wrap[i] = (m_cnt[i] == 0);
                        m_cnt[i]  = (m_cnt[i] + M - 1) % M;
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string nm);
        chk({nm, "/count"}, 64'(count), 64'(pack_model()));
        chk({nm, "/wrap"},  64'(wrap),  64'(m_wrap));
        chk({nm, "/snap"},  64'(sif.snap_out), 64'(m_snap));
        chk({nm, "/valid"}, 64'(sif.snap_valid_out), 64'(m_sv));
        chk({nm, "/ovf"},   64'(sif.snap_ovf_out), 64'(m_so));
    endtask

    task automatic idle_inputs();
        evt = '0; dir = '0; sat = '0; clr = '0; load = '0; lv = '0;
        sif.snap_req_in = 1'b0; sif.snap_ack_in = 1'b0;
        b_evt = '0; b_dir = '0; b_sat = '0; b_clr = '0; b_load = '0; b_lv = '0;
        bif.snap_req_in = 1'b0; bif.snap_ack_in = 1'b0;
        c_evt = '0; c_dir = '0; c_sat = '0; c_clr = '0; c_load = '0; c_lv = '0;
        cif.snap_req_in = 1'b0; cif.snap_ack_in = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  clr, load, evt, dir, sat;
        logic [15:0] lv;
        int          ch;
        int          exp_cnt;
        bit          exp_wrap;
    } vec_t;

    function automatic vec_t v(input logic [3:0] c, l, e, d, s, input logic [15:0] val,
                               input int ch, input int ec, input bit ew);
        vec_t r;
        r.clr = c; r.load = l; r.evt = e; r.dir = d; r.sat = s; r.lv = val;
        r.ch = ch; r.exp_cnt = ec; r.exp_wrap = ew;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        logic [N*W-1:0] snap_exp;

        // ---- reset state ----
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        compare_all("reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed vector table ----
        //            clr    load   evt    dir    sat    lv      ch exp    wrap
        tbl[0]  = v(4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 16'd39998, 1, 39998, 0);
        tbl[1]  = v(4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 16'd0,     1, 39999, 0);
        tbl[2]  = v(4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 16'd0,     1, 0,     1);
        tbl[3]  = v(4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 16'd0,     1, 1,     0);
        tbl[4]  = v(4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 16'd0,     2, 0,     0);
        tbl[5]  = v(4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 16'd0,     2, 0,     0);
        tbl[6]  = v(4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 16'd0,     2, 0,     0);
        tbl[7]  = v(4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 16'd0,     2, 0,     0);
        tbl[8]  = v(4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 16'd0,     2, 0,     0);
        tbl[9]  = v(4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 16'd0,     2, 39999, 1);
        tbl[10] = v(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd0,     2, 39999, 0);
        tbl[11] = v(4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 16'd7,     3, 7,     0);
        tbl[12] = v(4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 16'd500,   3, 0,     0);
        tbl[13] = v(4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 16'd500,   3, 500,   0);
        tbl[14] = v(4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 16'd65000, 3, 39999, 0);
        tbl[15] = v(4'h0, 4'h0, 4'h8, 4'h8, 4'h1, 16'd0,     3, 0,     1);

        for (int r = 0; r < 16; r++) begin
            clr = tbl[r].clr; load = tbl[r].load; evt = tbl[r].evt;
            dir = tbl[r].dir; sat = tbl[r].sat; lv = tbl[r].lv;
            step();
            chk($sformatf("vec%0d/count", r), 64'(count[tbl[r].ch*W +: W]), 64'(tbl[r].exp_cnt));
            chk($sformatf("vec%0d/wrap", r), 64'(wrap[tbl[r].ch]), 64'(tbl[r].exp_wrap));
            compare_all($sformatf("vec%0d", r));
        end
        idle_inputs();

        // ---- snapshot handshake ----
        for (int i = 0; i < N; i++) begin
            load = 4'(1 << i);
            lv   = 16'(10 * (i + 1));
            step();
        end
        idle_inputs();
        snap_exp = {16'd40, 16'd30, 16'd20, 16'd10};
        sif.snap_req_in = 1'b1;
        step();
        sif.snap_req_in = 1'b0;
        chk("snap1/data", 64'(sif.snap_out), 64'(snap_exp));
        chk("snap1/valid", 64'(sif.snap_valid_out), 64'd1);
        compare_all("snap1");

        evt = '1; dir = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            compare_all("snap_run");
        end
        chk("snap_stable/data", 64'(sif.snap_out), 64'(snap_exp));
        chk("snap_run/count", 64'(count), 64'({16'd43, 16'd33, 16'd23, 16'd13}));

        sif.snap_req_in = 1'b1;
        step();
        chk("snap_drop/ovf", 64'(sif.snap_ovf_out), 64'd1);
        chk("snap_drop/data", 64'(sif.snap_out), 64'(snap_exp));
        compare_all("snap_drop");

        sif.snap_ack_in = 1'b1;
        step();
        chk("snap_reack/data", 64'(sif.snap_out), 64'({16'd44, 16'd34, 16'd24, 16'd14}));
        chk("snap_reack/valid", 64'(sif.snap_valid_out), 64'd1);
        chk("snap_reack/ovf", 64'(sif.snap_ovf_out), 64'd0);
        compare_all("snap_reack");

        evt = '0;
        sif.snap_req_in = 1'b0;
        step();
        chk("snap_ack/valid", 64'(sif.snap_valid_out), 64'd0);
        compare_all("snap_ack");
        step();
        compare_all("snap_idle_ack");
        idle_inputs();

        // ---- asynchronous reset mid-count ----
        load = 4'h1; lv = 16'd123;
        step();
        load = '0;
        chk("pre_rst/ch0", 64'(count[W-1:0]), 64'd123);
        sif.snap_req_in = 1'b1;
        step();
        step();
        sif.snap_req_in = 1'b0;
        chk("pre_rst/ovf", 64'(sif.snap_ovf_out), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async/count", 64'(count), 64'd0);
        chk("rst_async/wrap", 64'(wrap), 64'd0);
        chk("rst_async/snap", 64'(sif.snap_out), 64'd0);
        chk("rst_async/valid", 64'(sif.snap_valid_out), 64'd0);
        chk("rst_async/ovf", 64'(sif.snap_ovf_out), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all("post_rst");

        // ---- randomized run against the model ----
        for (int k = 0; k < 600; k++) begin
            evt = 4'($urandom); dir = 4'($urandom); sat = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                clr[i]  = ($urandom_range(0, 31) == 0);
                load[i] = ($urandom_range(0, 15) == 0);
            end
            case ($urandom_range(0, 5))
                0: lv = 16'd39998;
                1: lv = 16'd1;
                2: lv = 16'd40000;
                3: lv = 16'd65535;
                default: lv = 16'($urandom);
            endcase
            sif.snap_req_in = ($urandom_range(0, 3) == 0);
            sif.snap_ack_in = ($urandom_range(0, 3) == 0);
            step();
            compare_all("rand");
        end
        idle_inputs();

        // ---- corner: WIDTH 4, MAX_COUNT 16, counts 0..15 then wraps ----
        b_evt = 1'b1; b_dir = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("w4_k%0d/count", k), 64'(b_count), 64'(k % 16));
            chk($sformatf("w4_k%0d/wrap", k), 64'(b_wrap), 64'(k == 16));
        end
        idle_inputs();

        // ---- corner: MAX_COUNT 2; every other step crosses the boundary ----
        // ch0 counts up (wraps 1->0), ch1 counts down (wraps 0->1), so one
        // of the two wrap bits is high in every cycle.
        c_evt = 2'b11; c_dir = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("m2_k%0d/count", k), 64'(c_count), (k % 2) ? 64'd3 : 64'd0);
            chk($sformatf("m2_k%0d/wrap", k), 64'(c_wrap), (k % 2) ? 64'd2 : 64'd1);
        end
        idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
